shift_sequencer_ctrl: RTL
=========================

// Module: shift_sequencer_ctrl
// PURPOSE
//  Multicycle controller for a logarithmic right barrel shifter in the CORDIC ln datapath.
//  Accepts an operand and a shift amount, then applies one power-of-two stage per cycle.
//  Stage k (k = 0..EWR-1) moves data right by 2**k when shift bit k is 1, using the
//  fill bit for vacated MSBs. One shifter stage is reused across EWR cycles.
//  Result is returned through a start/done handshake.
// PARAMETERS
//  SWR  26  datapath width (bits)
//  EWR  5   shift-amount width; number of stages; max shift = 2**EWR-1
// PORTS
//  clk          in   1    system clock, rising edge
//  rst          in   1    synchronous reset, active-high
//  start_i      in   1    request; sampled only when ready_o=1
//  data_i       in   SWR  operand, captured with start_i
//  shift_i      in   EWR  right-shift amount, captured with start_i
//  bit_shift_i  in   1    fill bit for vacated MSBs, captured with start_i
//  ready_o      out  1    controller can accept start_i this cycle
//  busy_o       out  1    shift stages in progress
//  done_o       out  1    one-cycle pulse; data_o is valid
//  data_o       out  SWR  shifted result, held until the next result
// BEHAVIOUR
//  Reset values: state=IDLE, ready_o=1, busy_o=0, done_o=0, data_o=0.
//  Internal registers are cleared on reset: work_r, amt_r, fill_r, and stage counter k_r.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE:  ready_o=1. If start_i=1, capture data_i->work_r, shift_i->amt_r,
//          bit_shift_i->fill_r, set k_r=0, and go to SHIFT.
//   SHIFT: busy_o=1, ready_o=0. Each cycle, every bit j gets
//          work_r[j] <= amt_r[k_r] ? ((j+2**k_r > SWR-1) ? fill_r : work_r[j+2**k_r]) : work_r[j].
//          k_r increments each cycle. After the stage with k_r=EWR-1, go to DONE.
//          On that same edge, load data_o with the final shifted value.
//   DONE:  done_o=1 for exactly one cycle, ready_o=1.
//          If start_i=1, capture the new operand and go to SHIFT (back-to-back).
//          Otherwise go to IDLE.
//  Latency: a start accepted at edge N gives done_o=1 in the cycle after edge N+EWR.
//   That is EWR+1 cycles from the accept edge. The latency is fixed and independent of the
//   shift value: every stage runs even when its amt_r bit is 0.
//  data_o changes only on entry to DONE, and holds between results.
//  Arithmetic: right shift only; no sign logic. An arithmetic shift is done by driving
//   bit_shift_i with the operand MSB.
//  Boundaries:
//   shift >= SWR (e.g. 26..31 when SWR=26): every result bit equals the fill bit.
//   shift = 0: data_o = data_i, still after the full latency.
//   start_i while in SHIFT: ignored, and no captured state changes.
//   data_i, shift_i and bit_shift_i may change freely after capture.
//   rst=1 in any state, including mid-SHIFT: the next edge applies the reset values.
//    The in-flight operation is discarded and no done_o pulse is produced.
//   rst and start_i asserted together: reset wins.
// TESTING  (SWR=26, EWR=5)
//  1. data=26'h3FFFFFF, shift=4, fill=0, start 1 cycle
//     -> done_o in the 6th cycle after the accept edge; data_o=26'h03FFFFF.
//  2. data=26'h0000000, shift=3, fill=1 -> data_o=26'h3800000.
//  3. data=26'h2AAAAAA, shift=31, fill=0 -> data_o=0.
//     Repeat with fill=1 -> data_o=26'h3FFFFFF.
//  4. data=26'h1234567, shift=0 -> data_o=26'h1234567, latency still EWR+1.
//     Also hold start_i high in SHIFT -> request ignored, single done_o.
//  5. Second start asserted in the DONE cycle -> accepted; next done_o 6 cycles later.
//     data_o holds the first result in between.
//  6. rst pulsed during the 3rd SHIFT cycle -> IDLE next cycle, data_o=0,
//     no done_o; a new start afterwards completes normally.

Source files
------------

// File: rtl/shift_sequencer_ctrl.sv
// Multicycle right barrel shifter controller: one power-of-two stage per cycle,
// EWR stages per operation, result returned through a start/done handshake.
module shift_sequencer_ctrl #(
    parameter int unsigned SWR = 26,
    parameter int unsigned EWR = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWR-1:0] data_i,
    input  logic [EWR-1:0] shift_i,
    input  logic           bit_shift_i,
    output logic           ready_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [SWR-1:0] data_o
);

    localparam int unsigned KW = (EWR > 1) ? $clog2(EWR) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SWR-1:0] work_q, work_d;
    logic [EWR-1:0] amt_q, amt_d;
    logic           fill_q, fill_d;
    logic [KW-1:0]  k_q, k_d;
    logic [SWR-1:0] data_q, data_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [2*SWR-1:0] ext_c;
    logic [SWR-1:0]   stage_c;
    int unsigned      stride_c;

    // One shifter stage: move right by 2**k_q when that amount bit is set.
    always_comb begin
        ext_c    = {{SWR{fill_q}}, work_q};
        stride_c = 32'd1 << k_q;
        stage_c  = work_q;
        if (amt_q[k_q]) begin
            if (stride_c >= SWR) begin
                stage_c = {SWR{fill_q}};
            end else begin
                stage_c = SWR'(ext_c >> stride_c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        k_d     = k_q;
        data_d  = data_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    work_d  = data_i;
                    amt_d   = shift_i;
                    fill_d  = bit_shift_i;
                    k_d     = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = stage_c;
                k_d    = k_q + KW'(1);
                if (k_q == KW'(EWR - 1)) begin
                    k_d     = '0;
                    data_d  = stage_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered, so decode them from the next state.
        ready_d = (state_d != SHIFT);
        busy_d  = (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            amt_q   <= '0;
            fill_q  <= 1'b0;
            k_q     <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            fill_q  <= fill_d;
            k_q     <= k_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign data_o  = data_q;

endmodule
